eth_tx_framer: RTL

ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

---
 rtl/eth_pkg.sv | 24 ++
 rtl/eth_tx_framer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet transmit framer: state encoding,
// framing bytes and default frame/gap sizes.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        PAD,
        FCS,
        DROP,
        IFG
    } tx_state_e;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam int         PREAMBLE_LEN  = 7;

    localparam int DEF_MIN_FRAME = 60;
    localparam int DEF_MAX_FRAME = 1514;
    localparam int DEF_IFG_LEN   = 12;

endpackage

// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: wraps client bytes with preamble/SFD, pads or
// truncates the body, appends the FCS from the external CRC stage, enforces the IFG.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int MIN_FRAME = DEF_MIN_FRAME,
    parameter int MAX_FRAME = DEF_MAX_FRAME,
    parameter int IFG_LEN   = DEF_IFG_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_sof,
    output logic        m_eof,
    output logic        crc_strt,
    output logic        crc_update,
    output logic [7:0]  crc_data,
    input  logic [31:0] crc_result,
    output logic        tx_err
);

    localparam logic [10:0] MIN_CNT = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_CNT = 11'(MAX_FRAME);
    // IDLE and PRE each take one cycle before the first preamble byte shows,
    // so the IFG state itself waits two cycles less than the visible gap.
    localparam int          IFG_WAIT = (IFG_LEN > 2) ? IFG_LEN - 2 : 1;
    localparam logic [15:0] IFG_LAST = 16'(IFG_WAIT - 1);

    tx_state_e   state_q, state_d;
    logic [10:0] byteCnt_q, byteCnt_d, byteInc;
    logic [2:0]  preCnt_q, preCnt_d;
    logic [2:0]  fcsIdx_q, fcsIdx_d;
    logic [31:0] fcs_q, fcs_d;
    logic        drop_q, drop_d;
    logic [15:0] ifgCnt_q, ifgCnt_d;
    logic [7:0]  mData_q, mData_d;
    logic        mValid_q, mValid_d;
    logic        mSof_q, mSof_d;
    logic        mEof_q, mEof_d;
    logic        slotFree;

    assign m_data  = mData_q;
    assign m_valid = mValid_q;
    assign m_sof   = mSof_q;
    assign m_eof   = mEof_q;

    always_comb begin
        slotFree   = !mValid_q || m_ready;
        byteInc    = byteCnt_q + 11'd1;
        state_d    = state_q;
        byteCnt_d  = byteCnt_q;
        preCnt_d   = preCnt_q;
        fcsIdx_d   = fcsIdx_q;
        fcs_d      = fcs_q;
        drop_d     = drop_q;
        ifgCnt_d   = ifgCnt_q;
        mData_d    = mData_q;
        mValid_d   = mValid_q;
        mSof_d     = mSof_q;
        mEof_d     = mEof_q;
        s_ready    = 1'b0;
        crc_strt   = 1'b0;
        crc_update = 1'b0;
        crc_data   = 8'h00;
        tx_err     = 1'b0;

        if (slotFree) begin
            mValid_d = 1'b0;
            mSof_d   = 1'b0;
            mEof_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    state_d  = PRE;
                    preCnt_d = 3'd0;
                end
            end
            PRE: begin
                if (slotFree) begin
                    mData_d  = PREAMBLE_BYTE;
                    mValid_d = 1'b1;
                    mSof_d   = (preCnt_q == 3'd0);
                    preCnt_d = preCnt_q + 3'd1;
                    if (preCnt_q == 3'(PREAMBLE_LEN - 1)) state_d = SFD;
                end
            end
            SFD: begin
                if (slotFree) begin
                    mData_d   = SFD_BYTE;
                    mValid_d  = 1'b1;
                    crc_strt  = 1'b1;
                    byteCnt_d = 11'd0;
                    fcsIdx_d  = 3'd0;
                    drop_d    = 1'b0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                s_ready = slotFree;
                if (s_valid && slotFree) begin
                    mData_d    = s_data;
                    mValid_d   = 1'b1;
                    crc_update = 1'b1;
                    crc_data   = s_data;
                    byteCnt_d  = byteInc;
                    if (s_last) begin
                        state_d = (byteInc < MIN_CNT) ? PAD : FCS;
                    end else if (byteInc == MAX_CNT) begin
                        tx_err  = 1'b1;
                        drop_d  = 1'b1;
                        state_d = FCS;
                    end
                end
            end
            PAD: begin
                if (slotFree) begin
                    mData_d    = 8'h00;
                    mValid_d   = 1'b1;
                    crc_update = 1'b1;
                    byteCnt_d  = byteInc;
                    if (byteInc == MIN_CNT) state_d = FCS;
                end
            end
            FCS: begin
                // First cycle only captures the CRC, which settles one cycle after the last update.
                if (fcsIdx_q == 3'd0) begin
                    fcs_d    = crc_result;
                    fcsIdx_d = 3'd1;
                end else if (slotFree) begin
                    mData_d  = fcs_q[7:0];
                    mValid_d = 1'b1;
                    mEof_d   = (fcsIdx_q == 3'd4);
                    fcs_d    = {8'h00, fcs_q[31:8]};
                    fcsIdx_d = fcsIdx_q + 3'd1;
                    if (fcsIdx_q == 3'd4) begin
                        state_d  = drop_q ? DROP : IFG;
                        ifgCnt_d = 16'd0;
                    end
                end
            end
            DROP: begin
                s_ready = !mValid_q;
                if (!mValid_q && s_valid && s_last) begin
                    state_d  = IFG;
                    ifgCnt_d = 16'd0;
                end
            end
            IFG: begin
                if (!mValid_q) begin
                    ifgCnt_d = ifgCnt_q + 16'd1;
                    if (ifgCnt_q == IFG_LAST) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            byteCnt_q <= 11'd0;
            preCnt_q  <= 3'd0;
            fcsIdx_q  <= 3'd0;
            fcs_q     <= 32'd0;
            drop_q    <= 1'b0;
            ifgCnt_q  <= 16'd0;
            mData_q   <= 8'h00;
            mValid_q  <= 1'b0;
            mSof_q    <= 1'b0;
            mEof_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            byteCnt_q <= byteCnt_d;
            preCnt_q  <= preCnt_d;
            fcsIdx_q  <= fcsIdx_d;
            fcs_q     <= fcs_d;
            drop_q    <= drop_d;
            ifgCnt_q  <= ifgCnt_d;
            mData_q   <= mData_d;
            mValid_q  <= mValid_d;
            mSof_q    <= mSof_d;
            mEof_q    <= mEof_d;
        end
    end

endmodule
